// File: rtl/udp_recv_if.sv
// Byte-stream bundle between a GMII-style receive source and the UDP receiver:
// the raw rx byte lane in, and the payload stream plus frame metadata out.
interface udp_recv_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_dv;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_sop;
  logic        o_eop;
  logic [47:0] o_src_mac;
  logic [31:0] o_src_ip;
  logic [15:0] o_src_port;
  logic [15:0] o_data_len;
  logic        o_done;
  logic [2:0]  o_status;

  modport master (
    output i_rx_data, i_rx_dv,
    input  o_data, o_valid, o_sop, o_eop, o_src_mac, o_src_ip, o_src_port,
           o_data_len, o_done, o_status
  );

  modport slave (
    input  i_rx_data, i_rx_dv,
    output o_data, o_valid, o_sop, o_eop, o_src_mac, o_src_ip, o_src_port,
           o_data_len, o_done, o_status
  );
endinterface

// File: rtl/udp_recv.sv
// UDP/IPv4 receiver: strips preamble and headers, filters MAC/IP/protocol/port,
// streams the payload and reports a per-frame status once the FCS has been checked.
module udp_recv #(
  parameter bit          FILTER_PORT = 1'b1,
  parameter logic [15:0] MAX_LEN     = 16'd1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  input  logic [15:0] i_my_port,
  udp_recv_if.slave   rx
);
  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_DST_MAC, S_SRC_MAC, S_ETHTYPE, S_IP_HDR,
    S_UDP_HDR, S_PAYLOAD, S_TAIL, S_DROP, S_DONE
  } state_t;

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_FCS   = 3'd1;
  localparam logic [2:0] ST_CSUM  = 3'd2;
  localparam logic [2:0] ST_FILT  = 3'd3;
  localparam logic [2:0] ST_TRUNC = 3'd4;
  localparam logic [2:0] ST_LEN   = 3'd5;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] csum_fold(input logic [31:0] acc);
    logic [31:0] s;
    s = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  state_t      state_r, next_s;
  logic [15:0] bc_r;
  logic [39:0] shift_r;
  logic [47:0] field_s;
  logic [31:0] crc_r, csum_r, csum_s;
  logic [15:0] ip_len_r, data_len_r;
  logic [2:0]  stat_r, stat_next_s;
  logic        quiet_r, quiet_next_s, gap_seen_r, len_bad_s, crc_en_s;
  logic [7:0]  data_r;
  logic        valid_r, sop_r, eop_r, done_r;
  logic [2:0]  status_r;
  logic [47:0] src_mac_r;
  logic [31:0] src_ip_r;
  logic [15:0] src_port_r;

  // Next-state, drop code and header checks for the byte currently on the lane
  always_comb begin
    field_s      = {shift_r, rx.i_rx_data};
    csum_s       = csum_r + {16'd0, shift_r[7:0], rx.i_rx_data};
    len_bad_s    = (field_s[15:0] < 16'd8) || ((field_s[15:0] - 16'd8) > MAX_LEN) ||
                   ({1'b0, ip_len_r} < ({1'b0, field_s[15:0]} + 17'd20));
    crc_en_s     = rx.i_rx_dv && (state_r inside {S_DST_MAC, S_SRC_MAC, S_ETHTYPE,
                                  S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_TAIL});
    next_s       = state_r;
    stat_next_s  = stat_r;
    quiet_next_s = quiet_r;
    case (state_r)
      S_IDLE: begin
        stat_next_s  = ST_OK;
        quiet_next_s = 1'b0;
        // Bytes seen before any gap (e.g. after reset mid-frame) are dropped silently
        if (rx.i_rx_dv) begin
          if (gap_seen_r && rx.i_rx_data == 8'h55) next_s = S_PREAMBLE;
          else begin next_s = S_DROP; quiet_next_s = 1'b1; end
        end else next_s = S_IDLE;
      end
      S_PREAMBLE: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if (rx.i_rx_data == 8'h55) begin
          if (bc_r == 16'd6) begin next_s = S_DROP; stat_next_s = ST_FILT; end
          else next_s = S_PREAMBLE;
        end
        else if (rx.i_rx_data == 8'hD5) next_s = S_DST_MAC;
        else begin next_s = S_DROP; stat_next_s = ST_FILT; end
      end
      S_DST_MAC: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if (bc_r == 16'd5) begin
          if (field_s == i_my_mac || field_s == 48'hFFFF_FFFF_FFFF) next_s = S_SRC_MAC;
          else begin next_s = S_DROP; stat_next_s = ST_FILT; end
        end else next_s = S_DST_MAC;
      end
      S_SRC_MAC: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if (bc_r == 16'd5) next_s = S_ETHTYPE;
        else next_s = S_SRC_MAC;
      end
      S_ETHTYPE: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if (bc_r == 16'd1) begin
          if (field_s[15:0] == 16'h0800) next_s = S_IP_HDR;
          else begin next_s = S_DROP; stat_next_s = ST_FILT; end
        end else next_s = S_ETHTYPE;
      end
      S_IP_HDR: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if ((bc_r == 16'd0 && rx.i_rx_data != 8'h45) ||
                 (bc_r == 16'd9 && rx.i_rx_data != 8'd17)) begin
          next_s = S_DROP; stat_next_s = ST_FILT;
        end
        else if (bc_r == 16'd19) begin
          if (csum_fold(csum_s) != 16'hFFFF) begin next_s = S_DROP; stat_next_s = ST_CSUM; end
          else if (field_s[31:0] != i_my_ip) begin next_s = S_DROP; stat_next_s = ST_FILT; end
          else next_s = S_UDP_HDR;
        end else next_s = S_IP_HDR;
      end
      S_UDP_HDR: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if (bc_r == 16'd3 && FILTER_PORT && field_s[15:0] != i_my_port) begin
          next_s = S_DROP; stat_next_s = ST_FILT;
        end
        else if (bc_r == 16'd5 && len_bad_s) begin next_s = S_DROP; stat_next_s = ST_LEN; end
        else if (bc_r == 16'd7) next_s = (data_len_r == 16'd0) ? S_TAIL : S_PAYLOAD;
        else next_s = S_UDP_HDR;
      end
      S_PAYLOAD: begin
        if (!rx.i_rx_dv) begin next_s = S_DONE; stat_next_s = ST_TRUNC; end
        else if (bc_r == data_len_r - 16'd1) next_s = S_TAIL;
        else next_s = S_PAYLOAD;
      end
      S_TAIL: begin
        if (!rx.i_rx_dv) begin
          next_s = S_DONE;
          if (bc_r < 16'd4) stat_next_s = ST_TRUNC;
          else stat_next_s = (crc_r == 32'hDEBB20E3) ? ST_OK : ST_FCS;
        end else next_s = S_TAIL;
      end
      S_DROP: begin
        if (!rx.i_rx_dv) next_s = quiet_r ? S_IDLE : S_DONE;
        else next_s = S_DROP;
      end
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // State register, byte counter, field shifter and drop bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      bc_r       <= 16'd0;
      shift_r    <= 40'd0;
      stat_r     <= ST_OK;
      quiet_r    <= 1'b0;
      gap_seen_r <= 1'b0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) bc_r <= 16'd0;
      else if (rx.i_rx_dv)   bc_r <= bc_r + 16'd1;
      else                   bc_r <= bc_r;
      shift_r    <= rx.i_rx_dv ? field_s[39:0] : shift_r;
      stat_r     <= stat_next_s;
      quiet_r    <= quiet_next_s;
      gap_seen_r <= gap_seen_r | ~rx.i_rx_dv;
    end
  end

  // Running FCS CRC, IP header checksum accumulator and IP total length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r    <= 32'hFFFF_FFFF;
      csum_r   <= 32'd0;
      ip_len_r <= 16'd0;
    end else begin
      if (state_r == S_IDLE || state_r == S_PREAMBLE) crc_r <= 32'hFFFF_FFFF;
      else if (crc_en_s) crc_r <= crc32_byte(crc_r, rx.i_rx_data);
      else crc_r <= crc_r;
      if (state_r != S_IP_HDR) csum_r <= 32'd0;
      else if (rx.i_rx_dv && bc_r[0]) csum_r <= csum_s;
      else csum_r <= csum_r;
      if (state_r == S_IP_HDR && rx.i_rx_dv && bc_r == 16'd3) ip_len_r <= field_s[15:0];
      else ip_len_r <= ip_len_r;
    end
  end

  // Sender identity and payload length, captured as each field completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_mac_r  <= 48'd0;
      src_ip_r   <= 32'd0;
      src_port_r <= 16'd0;
      data_len_r <= 16'd0;
    end else begin
      if (rx.i_rx_dv && state_r == S_SRC_MAC && bc_r == 16'd5) src_mac_r <= field_s;
      else src_mac_r <= src_mac_r;
      if (rx.i_rx_dv && state_r == S_IP_HDR && bc_r == 16'd15) src_ip_r <= field_s[31:0];
      else src_ip_r <= src_ip_r;
      if (rx.i_rx_dv && state_r == S_UDP_HDR && bc_r == 16'd1) src_port_r <= field_s[15:0];
      else src_port_r <= src_port_r;
      if (rx.i_rx_dv && state_r == S_UDP_HDR && bc_r == 16'd5) data_len_r <= field_s[15:0] - 16'd8;
      else data_len_r <= data_len_r;
    end
  end

  // Payload stream and end-of-frame status, one cycle behind the rx lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= 8'd0;
      valid_r  <= 1'b0;
      sop_r    <= 1'b0;
      eop_r    <= 1'b0;
      done_r   <= 1'b0;
      status_r <= ST_OK;
    end else begin
      valid_r  <= rx.i_rx_dv && state_r == S_PAYLOAD;
      data_r   <= (rx.i_rx_dv && state_r == S_PAYLOAD) ? rx.i_rx_data : 8'd0;
      sop_r    <= rx.i_rx_dv && state_r == S_PAYLOAD && bc_r == 16'd0;
      eop_r    <= rx.i_rx_dv && state_r == S_PAYLOAD && bc_r == data_len_r - 16'd1;
      done_r   <= (next_s == S_DONE);
      status_r <= (next_s == S_DONE) ? stat_next_s : status_r;
    end
  end

  assign rx.o_data     = data_r;
  assign rx.o_valid    = valid_r;
  assign rx.o_sop      = sop_r;
  assign rx.o_eop      = eop_r;
  assign rx.o_src_mac  = src_mac_r;
  assign rx.o_src_ip   = src_ip_r;
  assign rx.o_src_port = src_port_r;
  assign rx.o_data_len = data_len_r;
  assign rx.o_done     = done_r;
  assign rx.o_status   = status_r;
endmodule

// File: doc/udp_recv.md
Name: udp_recv

Overview:
- Receive-side counterpart of the UDP/IPv4 frame transmitter. Consumes a GMII-style byte stream (i_rx_data/i_rx_dv), strips the preamble and the Ethernet/IPv4/UDP headers, and filters on MAC, IP, protocol and port.
- Streams the UDP payload to the user side one byte per clock.
- Verifies the IP header checksum and the Ethernet FCS, and reports a per-frame status pulse when the frame ends.

Parameters:
- FILTER_PORT, 1, when 1 the UDP destination port must equal i_my_port; when 0 any port is accepted.
- MAX_LEN, 16'd1472, maximum accepted UDP payload length in bytes.

Ports:
- clk  in  1  system clock, one byte per cycle.
- rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_dv  in  1  byte valid; high for the whole frame from preamble through FCS.
- i_my_mac  in  48  local MAC address.
- i_my_ip  in  32  local IP address.
- i_my_port  in  16  local UDP port.
- o_data  out  8  payload byte.
- o_valid  out  1  o_data valid.
- o_sop  out  1  asserted with the first payload byte.
- o_eop  out  1  asserted with the last payload byte.
- o_src_mac  out  48  latched sender MAC.
- o_src_ip  out  32  latched sender IP.
- o_src_port  out  16  latched sender UDP port.
- o_data_len  out  16  payload length, equal to UDP length minus 8; valid from o_sop.
- o_done  out  1  one-cycle pulse at end of frame.
- o_status  out  3  valid with o_done: 0 OK, 1 FCS error, 2 IP checksum error, 3 filtered/not for us, 4 truncated, 5 length error.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; CRC register 32'hFFFFFFFF.
  - Reset asserted mid-frame: outputs clear immediately. After release the FSM stays in DROP until i_rx_dv is low, with no o_done.
- Byte counter bc, 16 bits: cleared on every state change, otherwise incremented per valid byte.
- State sequence: IDLE -> PREAMBLE -> DST_MAC(6) -> SRC_MAC(6) -> ETHTYPE(2) -> IP_HDR(20) -> UDP_HDR(8) -> PAYLOAD(o_data_len) -> TAIL -> DONE -> IDLE.
  - Any state can also exit to DROP. DROP -> DONE occurs when i_rx_dv goes low.
- IDLE: go to PREAMBLE on the first 0x55 with i_rx_dv=1.
- PREAMBLE:
  - 0x55 stays in PREAMBLE.
  - 0xD5 after 1..7 bytes of 0x55 goes to DST_MAC.
  - Any other byte, or more than 7 bytes of 0x55, goes to DROP with status 3.
- CRC:
  - CRC-32 uses reflected polynomial 0xEDB88320, LSB first. It updates on every byte from the first DST_MAC byte through the last FCS byte.
  - A frame is good when the register equals 32'hDEBB20E3 after the final byte.
- Filters, each evaluated on the byte that completes its field; a failure goes to DROP with status 3:
  - DST_MAC must equal i_my_mac or FF:FF:FF:FF:FF:FF.
  - ETHTYPE must equal 0x0800.
  - IP byte 0 must equal 0x45.
  - IP protocol (byte 9) must equal 17.
  - IP dst (bytes 16-19) must equal i_my_ip.
  - UDP dst port must equal i_my_port when FILTER_PORT=1.
- IP checksum:
  - 32-bit accumulator over the ten big-endian 16-bit header words.
  - Fold carries twice; the result must equal 16'hFFFF, otherwise DROP with status 2.
- Length:
  - UDP length < 8, UDP length - 8 > MAX_LEN, or IP total length < UDP length + 20 goes to DROP with status 5.
  - UDP length == 8 means zero payload: skip PAYLOAD (no o_valid) and go to TAIL.
- Latched fields: o_src_mac, o_src_ip and o_src_port are latched as their fields arrive and held until the next frame's SRC_MAC.
- PAYLOAD:
  - o_data/o_valid are registered, giving one cycle of latency from i_rx_data.
  - o_sop is on payload byte 0; o_eop is on byte o_data_len-1.
  - The UDP checksum field is ignored.
- TAIL: consume Ethernet padding and the 4 FCS bytes until i_rx_dv falls.
- Frame end, first cycle with i_rx_dv=0 in TAIL:
  - Fewer than 4 bytes in TAIL gives o_status 4; otherwise the CRC result gives 0 or 1.
  - o_done pulses one cycle later (DONE state).
- Truncation: i_rx_dv falling in any header or PAYLOAD state goes to DONE with status 4.
  - If payload bytes were already delivered, o_eop is not generated; the user discards on o_status != 0.
- Payload bytes are forwarded before the FCS is known. Consumers must commit only on o_done with o_status==0.
- The minimum inter-frame gap is 1 idle cycle; the FSM is back in IDLE by the second cycle after i_rx_dv falls.

Test Plan:
- Valid frame (7x55, D5, matching MAC/IP/port, 18-byte payload 00..11, pad to 60 bytes, correct FCS) -> 18 o_valid bytes 00..11, o_sop on 00, o_eop on 11, o_data_len=18, o_done with o_status=0.
- Same frame with one payload byte flipped in flight -> 18 bytes delivered, o_done with o_status=1.
- Wrong dst IP, or protocol=6 -> no o_valid, o_done with o_status=3; a broadcast-MAC frame that is otherwise valid -> status 0.
- Corrupted IP checksum word -> no payload, o_status=2; UDP length=4 -> o_status=5.
- i_rx_dv dropped after 5 payload bytes -> 5 bytes delivered with no o_eop, o_status=4. Back-to-back valid frames with a 1-cycle gap -> both report status 0.
- rst_n pulsed low mid-payload -> outputs 0 immediately, no o_done; the next valid frame is received with status 0.
